// File: rtl/block_stream_arbiter.sv
// Round-robin arbiter that captures one requester's block and serializes it
// MSB byte first to a ready/valid byte sink, tagging the stream with the grant ID.
module block_stream_arbiter #(
  parameter  int unsigned NUM_REQ     = 2,
  parameter  int unsigned BLOCK_BYTES = 16,
  localparam int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic [NUM_REQ-1:0]                     req_valid_in,
  input  logic [NUM_REQ-1:0][BLOCK_BYTES-1:0][7:0] req_block_in,
  output logic [NUM_REQ-1:0]                     req_ready_out,
  input  logic                                   abort_in,
  output logic [7:0]                             byte_out,
  output logic                                   byte_valid_out,
  input  logic                                   byte_ready_in,
  output logic [ID_W-1:0]                        grant_id_out,
  output logic                                   busy_out,
  output logic                                   block_done_out
);

  localparam int unsigned CNT_W = $clog2(BLOCK_BYTES + 1);
  localparam int unsigned IDX_W = $clog2(BLOCK_BYTES);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [ID_W-1:0]                 rr_q, rr_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [BLOCK_BYTES-1:0][7:0]     buf_q, buf_d;
  logic [NUM_REQ-1:0]              req_ready_q, req_ready_d;
  logic [7:0]                      byte_q, byte_d;
  logic                            valid_q, valid_d;
  logic [ID_W-1:0]                 grant_q, grant_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;

  logic                            found_c;
  logic [ID_W-1:0]                 grant_c;
  logic [ID_W-1:0]                 idx_c;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    found_c = 1'b0;
    grant_c = '0;
    idx_c   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx_c = ID_W'((32'(rr_q) + 32'(i)) % NUM_REQ);
      if (!found_c && req_valid_in[idx_c]) begin
        found_c = 1'b1;
        grant_c = idx_c;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    req_ready_d = '0;
    byte_d      = byte_q;
    valid_d     = valid_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        byte_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        // Abort in IDLE suppresses arbitration for that cycle.
        if (found_c && !abort_in) begin
          req_ready_d[grant_c] = 1'b1;
          buf_d                = req_block_in[grant_c];
          byte_d               = req_block_in[grant_c][BLOCK_BYTES-1];
          cnt_d                = CNT_W'(BLOCK_BYTES);
          grant_d              = grant_c;
          rr_d                 = ID_W'((32'(grant_c) + 32'd1) % NUM_REQ);
          valid_d              = 1'b1;
          busy_d               = 1'b1;
          state_d              = STREAM;
        end
      end

      STREAM: begin
        if (abort_in) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          byte_d  = '0;
          cnt_d   = '0;
        end else if (byte_ready_in) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            byte_d  = '0;
            cnt_d   = '0;
          end else begin
            // Present the byte below the one just accepted.
            cnt_d  = cnt_q - CNT_W'(1);
            byte_d = buf_q[IDX_W'(cnt_q - CNT_W'(2))];
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Block buffer contents are don't-care after reset.
  always_ff @(posedge clk_in) begin
    buf_q <= buf_d;
  end

  assign req_ready_out  = req_ready_q;
  assign byte_out       = byte_q;
  assign byte_valid_out = valid_q;
  assign grant_id_out   = grant_q;
  assign busy_out       = busy_q;
  assign block_done_out = done_q;

endmodule
